// File: rtl/norm_shift_if.sv
// Operand and result handshake bundle for norm_shift_ctrl.
// slave  : the normaliser (accepts operands, produces results)
// master : the producer/consumer driving and draining the normaliser
interface norm_shift_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_lzc;
  logic        out_zero;
  logic        out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lzc, out_zero, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lzc, out_zero, out_sat
  );
endinterface

// File: rtl/norm_shift_ctrl.sv
// Sequential normalisation controller feeding a 16-bit barrel left shifter.
// Scans the captured operand one bit per cycle for the leading one (bounded
// by LZC_LIMIT), drives the shifter from registers, then captures the
// shifted result and presents it on the output handshake.
// Optional build macro NORM_SHIFT_CNT_EN adds an 8-bit wrapping count of
// completed output handshakes on port norm_count.
module norm_shift_ctrl #(
  parameter int LZC_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  norm_shift_if.slave bus,
  output logic [15:0] sh_in,
  output logic [3:0]  sh_ctrl,
  input  logic [15:0] sh_out
`ifdef NORM_SHIFT_CNT_EN
  ,
  output logic [7:0]  norm_count
`endif
);

  localparam logic [4:0] LIMIT = 5'(LZC_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_data;
  logic [4:0]  r_cnt;
  logic [15:0] r_out_data;
  logic [4:0]  r_out_lzc;
  logic        r_out_zero;
  logic        r_out_sat;
  logic [3:0]  w_idx;
  logic        w_bit;
  logic        w_in_ready;
  logic        w_out_valid;

  // Bit under test walks down from the MSB as the count rises.
  assign w_idx = 4'd15 - r_cnt[3:0];

  // State register; reset abandons any operand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake flags.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_bit       = r_data[w_idx];
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_data == 16'h0000) w_next = HOLD;
          else                         w_next = SCAN;
        end
      end
      SCAN: begin
        if (w_bit || (r_cnt == LIMIT)) w_next = SHIFT;
      end
      SHIFT: w_next = HOLD;
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, leading-zero count and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_lzc  <= '0;
      r_out_zero <= 1'b0;
      r_out_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_data <= bus.in_data;
            r_cnt  <= '0;
            // A zero operand has no leading one; its result is fixed and
            // the shifter is bypassed entirely.
            if (bus.in_data == 16'h0000) begin
              r_out_data <= '0;
              r_out_lzc  <= 5'd16;
              r_out_zero <= 1'b1;
              r_out_sat  <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (w_bit)                r_out_sat <= 1'b0;
          else if (r_cnt == LIMIT)  r_out_sat <= 1'b1;
          else                      r_cnt     <= r_cnt + 5'd1;
        end
        SHIFT: begin
          r_out_data <= sh_out;
          r_out_lzc  <= r_cnt;
          r_out_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef NORM_SHIFT_CNT_EN
  logic [7:0] r_norm_count;

  // Completed output handshakes, wrapping naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_norm_count <= '0;
    else if (w_out_valid && bus.out_ready) r_norm_count <= r_norm_count + 8'd1;
  end

  assign norm_count = r_norm_count;
`else
  // Handshake counter not built in this configuration.
`endif

  assign sh_in         = r_data;
  assign sh_ctrl       = r_cnt[3:0];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_lzc   = r_out_lzc;
  assign bus.out_zero  = r_out_zero;
  assign bus.out_sat   = r_out_sat;

endmodule
